// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared FSM state type and counter sizing for seq_multiplier.
// Revision : 1.0  initial release
// ============================================================================
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter wide enough to hold the step count itself.
  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(width / bpc) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_pp_row.sv
`default_nettype none
// ============================================================================
// Module   : mul_pp_row
// Purpose  : Partial product of an unsigned multiplicand and a short slice.
// Revision : 1.0  initial release
// ============================================================================
module mul_pp_row #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0]                i_a,
  input  logic [BITS_PER_CYCLE-1:0]       i_slice,
  output logic [WIDTH+BITS_PER_CYCLE-1:0] o_pp
);

  if (BITS_PER_CYCLE == 1) begin : g_radix2
    assign o_pp = i_slice[0] ? {1'b0, i_a} : '0;
  end else begin : g_radix4
    logic [WIDTH+BITS_PER_CYCLE-1:0] w_a_ext;
    logic [WIDTH+BITS_PER_CYCLE-1:0] w_s_ext;

    assign w_a_ext = {{BITS_PER_CYCLE{1'b0}}, i_a};
    assign w_s_ext = {{WIDTH{1'b0}}, i_slice};
    assign o_pp    = w_a_ext * w_s_ext;
  end

endmodule
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Fixed-latency shift-add multiplier, signed or unsigned, radix 2/4.
// Revision : 1.0  initial release
// ============================================================================
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P
);

  localparam int c_steps = WIDTH / BITS_PER_CYCLE;
  localparam int c_cnt_w = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam int c_acc_w = 2 * WIDTH + 1;
  localparam int c_pp_w  = WIDTH + BITS_PER_CYCLE;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_load;
  logic                  w_step;
  logic                  w_last;

  logic [WIDTH-1:0]      r_a_mag;
  logic [WIDTH-1:0]      r_b_mag;
  logic                  r_neg;
  logic [c_acc_w-1:0]    r_acc;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [2*WIDTH-1:0]    r_p;

  logic [WIDTH-1:0]      w_a_mag;
  logic [WIDTH-1:0]      w_b_mag;
  logic [c_pp_w-1:0]     w_pp;
  logic [c_acc_w-1:0]    w_pp_ext;
  logic [c_cnt_w:0]      w_shamt;
  logic [c_acc_w-1:0]    w_acc_next;
  logic [2*WIDTH-1:0]    w_prod;
  logic [2*WIDTH-1:0]    w_p_final;

  assign w_last = (r_cnt == c_cnt_w'(c_steps - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = BUSY;
      BUSY:    if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    w_load    = (r_state == IDLE) && in_valid;
    w_step    = (r_state == BUSY);
  end

  // -2^(WIDTH-1) maps onto itself, which is its correct unsigned magnitude.
  assign w_a_mag = (signed_mode && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign w_b_mag = (signed_mode && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

  mul_pp_row #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_pp_row (
    .i_a     (r_a_mag),
    .i_slice (r_b_mag[BITS_PER_CYCLE-1:0]),
    .o_pp    (w_pp)
  );

  assign w_pp_ext   = {{(c_acc_w - c_pp_w){1'b0}}, w_pp};
  assign w_shamt    = (BITS_PER_CYCLE == 2) ? {r_cnt, 1'b0} : {1'b0, r_cnt};
  assign w_acc_next = r_acc + (w_pp_ext << w_shamt);
  assign w_prod     = w_acc_next[2*WIDTH-1:0];
  assign w_p_final  = r_neg ? -w_prod : w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_mag <= '0;
      r_b_mag <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else if (w_load) begin
      r_a_mag <= w_a_mag;
      r_b_mag <= w_b_mag;
      r_neg   <= signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_acc   <= w_acc_next;
      r_b_mag <= r_b_mag >> BITS_PER_CYCLE;
      r_cnt   <= r_cnt + c_cnt_w'(1);
      if (w_last) r_p <= w_p_final;
    end
  end

  assign P = r_p;

endmodule
`default_nettype wire
